// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer and the datapath of the 8-bit bus computer.
//   opcode, carry_flag, zero_flag : datapath -> sequencer (IR upper nibble, latched flags)
//   step                          : sequencer -> datapath (current microstep, visibility only)
//   pc_* / mar_load / ram_* / ir_* / load_a / write_a / load_b / write_alu /
//   enable_sub / flag_load / out_load : sequencer -> datapath strobes
//   halt                          : sequencer stopped
interface control_sequencer_if;
  logic [3:0] opcode;
  logic       carry_flag;
  logic       zero_flag;
  logic [2:0] step;
  logic       pc_write;
  logic       pc_inc;
  logic       pc_load;
  logic       mar_load;
  logic       ram_write;
  logic       ram_load;
  logic       ir_load;
  logic       ir_write;
  logic       load_a;
  logic       write_a;
  logic       load_b;
  logic       write_alu;
  logic       enable_sub;
  logic       flag_load;
  logic       out_load;
  logic       halt;

  modport master (
    input  opcode, carry_flag, zero_flag,
    output step, pc_write, pc_inc, pc_load, mar_load, ram_write, ram_load, ir_load, ir_write,
           load_a, write_a, load_b, write_alu, enable_sub, flag_load, out_load, halt
  );

  modport slave (
    output opcode, carry_flag, zero_flag,
    input  step, pc_write, pc_inc, pc_load, mar_load, ram_write, ram_load, ir_load, ir_write,
           load_a, write_a, load_b, write_alu, enable_sub, flag_load, out_load, halt
  );
endinterface

// File: rtl/control_sequencer.sv
// Microcoded control unit: steps a fixed five-state fetch/execute cycle and decodes the
// opcode into every bus-drive and register-load strobe of the 8-bit bus computer.
// Ports:
//   clk   : system clock, all state changes on the rising edge
//   clear : synchronous active-high reset
//   bus   : control_sequencer_if master modport (opcode/flags in, step/strobes/halt out)
module control_sequencer (
  input logic                  clk,
  input logic                  clear,
  control_sequencer_if.master  bus
);

  typedef enum logic [2:0] {StT0, StT1, StT2, StT3, StT4} step_e;

  step_e step_q;
  logic  halted_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      step_q   <= StT0;
      halted_q <= 1'b0;
    end else if (!halted_q) begin
      // HLT takes effect at the edge closing T2, so the frozen step reads 3.
      if (step_q == StT2 && bus.opcode == 4'hF) begin
        halted_q <= 1'b1;
      end
      unique case (step_q)
        StT0:    step_q <= StT1;
        StT1:    step_q <= StT2;
        StT2:    step_q <= StT3;
        StT3:    step_q <= StT4;
        default: step_q <= StT0;
      endcase
    end
  end

  assign bus.step = clear ? 3'd0 : step_q;
  assign bus.halt = halted_q & ~clear;

  always_comb begin
    bus.pc_write   = 1'b0;
    bus.pc_inc     = 1'b0;
    bus.pc_load    = 1'b0;
    bus.mar_load   = 1'b0;
    bus.ram_write  = 1'b0;
    bus.ram_load   = 1'b0;
    bus.ir_load    = 1'b0;
    bus.ir_write   = 1'b0;
    bus.load_a     = 1'b0;
    bus.write_a    = 1'b0;
    bus.load_b     = 1'b0;
    bus.write_alu  = 1'b0;
    bus.enable_sub = 1'b0;
    bus.flag_load  = 1'b0;
    bus.out_load   = 1'b0;
    if (!clear && !halted_q) begin
      unique case (step_q)
        StT0: begin
          bus.pc_write = 1'b1;
          bus.mar_load = 1'b1;
        end
        StT1: begin
          bus.ram_write = 1'b1;
          bus.ir_load   = 1'b1;
          bus.pc_inc    = 1'b1;
        end
        StT2: begin
          case (bus.opcode)
            4'h1, 4'h2, 4'h3, 4'h4: begin
              bus.ir_write = 1'b1;
              bus.mar_load = 1'b1;
            end
            4'h5: begin
              bus.ir_write = 1'b1;
              bus.load_a   = 1'b1;
            end
            4'h6: begin
              bus.ir_write = 1'b1;
              bus.pc_load  = 1'b1;
            end
            4'h7: begin
              bus.ir_write = 1'b1;
              bus.pc_load  = bus.carry_flag;
            end
            4'h8: begin
              bus.ir_write = 1'b1;
              bus.pc_load  = bus.zero_flag;
            end
            4'hE: begin
              bus.write_a  = 1'b1;
              bus.out_load = 1'b1;
            end
            default: ;
          endcase
        end
        StT3: begin
          case (bus.opcode)
            4'h1: begin
              bus.ram_write = 1'b1;
              bus.load_a    = 1'b1;
            end
            4'h2, 4'h3: begin
              bus.ram_write = 1'b1;
              bus.load_b    = 1'b1;
            end
            4'h4: begin
              bus.write_a  = 1'b1;
              bus.ram_load = 1'b1;
            end
            default: ;
          endcase
        end
        StT4: begin
          if (bus.opcode == 4'h2 || bus.opcode == 4'h3) begin
            bus.write_alu  = 1'b1;
            bus.load_a     = 1'b1;
            bus.flag_load  = 1'b1;
            bus.enable_sub = (bus.opcode == 4'h3);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
